muldiv: RTL and testbench
=========================

# muldiv

Multiply/divide unit in the E stage of the five-stage MIPS pipeline: the execution responder to the controller's `start`/`mdctr`/`hiwrite`/`lowrite` requests, reporting occupancy back on `busy`. It holds the architectural HI/LO registers, runs signed and unsigned multiply and divide with fixed multi-cycle latency, and services `mthi`/`mtlo` writes. `mfhi`/`mflo` read `hi`/`lo` combinationally.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for `mult`/`multu`.
- `DIV_CYCLES`, default 10: busy cycles for `div`/`divu`.

Ports, one per line as name, direction, width, meaning:
- `clk` input 1: the single clock; all state updates on its rising edge.
- `rst` input 1: reset, synchronous and active-high; clears all state.
- `start` input 1: one-cycle request to begin the operation selected by `mdctr`.
- `mdctr` input 3: operation select. 0 = mult, 1 = multu, 2 = div, 3 = divu; 4–7 are reserved.
- `a` input 32: rs operand after forwarding; also the `mthi`/`mtlo` data.
- `b` input 32: rt operand after forwarding.
- `hiwrite` input 1: write `a` into HI (`mthi`).
- `lowrite` input 1: write `a` into LO (`mtlo`).
- `busy` output 1: an operation is in flight.
- `hi` output 32: HI register.
- `lo` output 32: LO register.

## Operation
- **States:** IDLE and RUN.
  - A 4-bit down-counter `cnt` tracks the run.
  - Registers `pend_hi` and `pend_lo` hold the computed result.
- **IDLE with `start` and a valid `mdctr` (0–3):**
  - `a` and `b` are consumed at this edge.
  - The result is computed from them and latched into `pend_hi`/`pend_lo`.
  - `cnt` loads `MULT_CYCLES-1` or `DIV_CYCLES-1`, and the state moves to RUN.
- **IDLE with `start` and a reserved `mdctr` (4–7):** no effect.
- **RUN:** `cnt` decrements each cycle. On the edge where `cnt`==0:
  - `hi` and `lo` load `pend_hi` and `pend_lo`;
  - the state returns to IDLE.
- **`busy`** = (state == RUN). It is a registered output.
- **Arithmetic:**
  - mult: 64-bit signed product.
  - multu: 64-bit unsigned product.
  - In both cases `hi` = [63:32] and `lo` = [31:0].
  - div/divu: `lo` = quotient and `hi` = remainder.
  - Signed quotient truncates toward zero; the remainder takes the sign of the dividend.
  - Signed 0x80000000 / 0xFFFFFFFF gives `lo` = 0x80000000 and `hi` = 0.
- **Divide by zero (`b` == 0, div or divu):**
  - Runs the full `DIV_CYCLES` with `busy` asserted.
  - `hi` and `lo` are left unchanged at completion.
- **`hiwrite`/`lowrite` in IDLE without `start`:**
  - The write takes effect at the edge.
  - Both may assert together; each register is written independently.
- **Simultaneous events:**
  - `start` with a valid op in the same cycle as `hiwrite`/`lowrite`: `start` wins and the writes are dropped.
  - `start`, `hiwrite` or `lowrite` while `busy`: ignored. The controller stalls these, so this is a protection only.
- **Reset:** at any time, including mid-RUN:
  - `hi`, `lo`, `pend_hi`, `pend_lo` and `cnt` go to 0;
  - state goes to IDLE and `busy` to 0;
  - any in-flight result is discarded.

## Timing
- `start` is sampled at edge T0.
- `busy` = 1 in cycles T0+1 … T0+N, where N = `MULT_CYCLES` or `DIV_CYCLES`.
- At edge T0+N, `hi`/`lo` update and `busy` falls.
- The earliest next `start` is sampled at edge T0+N. Back-to-back operations therefore have no bubble beyond N.
- `mthi`/`mtlo` latency is 1 edge. The new value is visible on `hi`/`lo` the next cycle.
- `hi`, `lo` and `busy` are purely registered, with no combinational path from any input.

## Structure
- **Shared package `mips_pkg`** holds:
  - the `mdctr` encodings `MD_MULT`, `MD_MULTU`, `MD_DIV`, `MD_DIVU`;
  - default cycle counts `MD_MULT_CYCLES` = 5 and `MD_DIV_CYCLES` = 10.
  - The controller's `mainctrE` and `hazardmonitor` use the same package.
- **Sub-module `md_arith`:** one natural, combinational sub-module.
  - Inputs: `a`, `b`, `mdctr`.
  - Outputs: 64-bit `{res_hi, res_lo}` and `div0`.
  - It contains the signed/unsigned multiply and divide and the sign-fix logic.
- **Top level** holds the FSM, the counter, the pending registers and HI/LO.

## Test plan
- **mult:** `a`=0xFFFFFFFE (−2), `b`=3, mult → `busy` high exactly 5 cycles. Then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA.
- **multu and back-to-back div:** same operands with multu → `hi`=0x00000002, `lo`=0xFFFFFFFA. Then issue div `a`=−7, `b`=2 at the edge `busy` falls → after 10 cycles `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- **divu by zero and `mthi` in IDLE:** divu with `b`=0 and `hi`/`lo` preloaded to 0x11111111 → `busy` 10 cycles, then `hi`/`lo` unchanged. Next, `hiwrite`=1 with `a`=0x12345678 → `hi`=0x12345678 next cycle; `lo` unchanged.
- **Signed overflow case:** div 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- **Reset and ignored requests:** `rst` at cycle 3 of a mult → next cycle `busy`=0, `hi`=`lo`=0, and no later commit. In a separate run, `start` or `lowrite` pulsed mid-RUN → ignored, and the original result commits on schedule.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings and defaults for the E-stage multiply/divide path.
package mips_pkg;

   localparam logic [2:0] MD_MULT  = 3'd0;
   localparam logic [2:0] MD_MULTU = 3'd1;
   localparam logic [2:0] MD_DIV   = 3'd2;
   localparam logic [2:0] MD_DIVU  = 3'd3;

   localparam int MD_MULT_CYCLES = 5;
   localparam int MD_DIV_CYCLES  = 10;

   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_RUN  = 1'b1
   } md_state_e;

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide core. Works on operand magnitudes and
// restores the sign afterwards, so one unsigned multiplier and one unsigned
// divider serve both the signed and unsigned forms.
module md_arith
   import mips_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [2:0]  mdctr,
   output logic [31:0] res_hi,
   output logic [31:0] res_lo,
   output logic        div0
);

   logic        is_signed;
   logic        is_div;
   logic [31:0] mag_a;
   logic [31:0] mag_b;
   logic [31:0] div_b;
   logic [63:0] prod_mag;
   logic [63:0] prod;
   logic [31:0] q_mag;
   logic [31:0] r_mag;
   logic [31:0] quo;
   logic [31:0] rem;

   // Magnitude arithmetic with sign fix-up; -2^31 maps onto itself, which
   // makes 0x80000000 / -1 come out as 0x80000000 with remainder 0.
   always_comb begin
      is_signed = (mdctr == MD_MULT) || (mdctr == MD_DIV);
      is_div    = (mdctr == MD_DIV)  || (mdctr == MD_DIVU);
      mag_a     = (is_signed && a[31]) ? -a : a;
      mag_b     = (is_signed && b[31]) ? -b : b;
      div0      = is_div && (b == 32'd0);
      div_b     = (b == 32'd0) ? 32'd1 : mag_b;

      prod_mag  = {32'd0, mag_a} * {32'd0, mag_b};
      prod      = (is_signed && (a[31] ^ b[31])) ? -prod_mag : prod_mag;

      q_mag     = mag_a / div_b;
      r_mag     = mag_a % div_b;
      quo       = (is_signed && (a[31] ^ b[31])) ? -q_mag : q_mag;
      rem       = (is_signed && a[31]) ? -r_mag : r_mag;

      if (is_div) begin
         res_hi = rem;
         res_lo = quo;
      end else begin
         res_hi = prod[63:32];
         res_lo = prod[31:0];
      end
   end

endmodule

// File: rtl/muldiv.sv
// E-stage multiply/divide unit: HI/LO registers plus a fixed-latency
// sequencer that commits a precomputed result after N busy cycles.
//
// state   | meaning
// --------+---------------------------------------------------------------
// MD_IDLE | no operation in flight; mthi/mtlo writes and start accepted
// MD_RUN  | counting down; commit pend_hi/pend_lo when cnt reaches zero
module muldiv
   import mips_pkg::*;
#(
   parameter int MULT_CYCLES = MD_MULT_CYCLES,
   parameter int DIV_CYCLES  = MD_DIV_CYCLES
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [2:0]  mdctr,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        hiwrite,
   input  logic        lowrite,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
   localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

   md_state_e   state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] pend_hi_q, pend_hi_d;
   logic [31:0] pend_lo_q, pend_lo_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic        busy_q, busy_d;

   logic        start_ok;
   logic        accept;
   logic [31:0] res_hi;
   logic [31:0] res_lo;
   logic        div0;

   md_arith u_arith (
      .a      (a),
      .b      (b),
      .mdctr  (mdctr),
      .res_hi (res_hi),
      .res_lo (res_lo),
      .div0   (div0)
   );

   // Next-state: a new op may be accepted in IDLE or on the commit edge, so
   // back-to-back ops see no bubble. A divide by zero parks the value HI/LO
   // will hold at that edge in the pending registers, so commit is a no-op.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pend_hi_d = pend_hi_q;
      pend_lo_d = pend_lo_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      busy_d    = busy_q;
      accept    = 1'b0;
      start_ok  = start && !mdctr[2];

      case (state_q)
         MD_IDLE: begin
            if (start_ok) begin
               accept = 1'b1;
            end else begin
               if (hiwrite) hi_d = a;
               if (lowrite) lo_d = a;
            end
         end
         MD_RUN: begin
            if (cnt_q == 4'd0) begin
               hi_d    = pend_hi_q;
               lo_d    = pend_lo_q;
               state_d = MD_IDLE;
               busy_d  = 1'b0;
               accept  = start_ok;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
      endcase

      if (accept) begin
         pend_hi_d = div0 ? hi_d : res_hi;
         pend_lo_d = div0 ? lo_d : res_lo;
         cnt_d     = mdctr[1] ? DIV_LOAD : MULT_LOAD;
         state_d   = MD_RUN;
         busy_d    = 1'b1;
      end
   end

   // State register with synchronous reset that discards any in-flight op.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= MD_IDLE;
         cnt_q     <= 4'd0;
         pend_hi_q <= 32'd0;
         pend_lo_q <= 32'd0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pend_hi_q <= pend_hi_d;
         pend_lo_q <= pend_lo_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         busy_q    <= busy_d;
      end
   end

   assign busy = busy_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv.sv
// Bench for muldiv: a vector table of operations plus hand-written
// sequences for back-to-back issue, reset mid-run and ignored requests.
module tb_muldiv;
   import mips_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  mdctr = 3'd0;
   logic [31:0] a_in = 32'd0;
   logic [31:0] b_in = 32'd0;
   logic        hiwrite = 1'b0;
   logic        lowrite = 1'b0;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   int nchk = 0;
   int nerr = 0;

   typedef struct {
      logic [2:0]  md;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] pre_hi;
      logic [31:0] pre_lo;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
      int          n;
   } vec_t;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          n;
   } exp_t;

   vec_t vecs[11];
   exp_t sb[$];

   muldiv dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .mdctr   (mdctr),
      .a       (a_in),
      .b       (b_in),
      .hiwrite (hiwrite),
      .lowrite (lowrite),
      .busy    (busy),
      .hi      (hi),
      .lo      (lo)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic preload(input logic [31:0] ph, input logic [31:0] pl);
      a_in = ph; hiwrite = 1'b1;
      tick();
      hiwrite = 1'b0; a_in = pl; lowrite = 1'b1;
      tick();
      lowrite = 1'b0;
   endtask

   task automatic drive_start(input logic [2:0] md, input logic [31:0] av, input logic [31:0] bv);
      start = 1'b1; mdctr = md; a_in = av; b_in = bv;
      tick();
      start = 1'b0;
   endtask

   task automatic push_exp(input logic [31:0] eh, input logic [31:0] el, input int n);
      exp_t e;
      e.hi = eh; e.lo = el; e.n = n;
      sb.push_back(e);
   endtask

   // Counts busy samples until busy drops (bounded), then compares against
   // the oldest scoreboard entry.
   task automatic wait_done(input string name);
      exp_t e;
      int   n;
      n = 0;
      while (busy === 1'b1 && n < 40) begin
         n++;
         tick();
      end
      if (sb.size() == 0) begin
         nchk++; nerr++;
         $display("FAIL %s: scoreboard empty at completion", name);
      end else begin
         e = sb.pop_front();
         check({name, "/busy_cycles"}, 32'(n), 32'(e.n));
         check({name, "/hi"}, hi, e.hi);
         check({name, "/lo"}, lo, e.lo);
      end
   endtask

   initial begin
      vecs[0]  = '{MD_MULT,  32'hFFFFFFFE, 32'd3,        32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFA, 5};
      vecs[1]  = '{MD_MULTU, 32'hFFFFFFFE, 32'd3,        32'h0, 32'h0, 32'h00000002, 32'hFFFFFFFA, 5};
      vecs[2]  = '{MD_DIV,   32'hFFFFFFF9, 32'd2,        32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
      vecs[3]  = '{MD_DIVU,  32'h00001234, 32'd0,        32'h11111111, 32'h11111111, 32'h11111111, 32'h11111111, 10};
      vecs[4]  = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h1, 32'h2, 32'h00000000, 32'h80000000, 10};
      vecs[5]  = '{MD_DIVU,  32'hFFFFFFF9, 32'd2,        32'h0, 32'h0, 32'h00000001, 32'h7FFFFFFC, 10};
      vecs[6]  = '{MD_DIV,   32'd7,        32'hFFFFFFFE, 32'h0, 32'h0, 32'h00000001, 32'hFFFFFFFD, 10};
      vecs[7]  = '{MD_MULT,  32'h80000000, 32'h80000000, 32'h0, 32'h0, 32'h40000000, 32'h00000000, 5};
      vecs[8]  = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 32'hFFFFFFFE, 32'h00000001, 5};
      vecs[9]  = '{MD_DIV,   32'd5,        32'd0,        32'hAAAAAAAA, 32'h55555555, 32'hAAAAAAAA, 32'h55555555, 10};
      vecs[10] = '{MD_DIV,   32'd100,      32'd7,        32'h0, 32'h0, 32'h00000002, 32'h0000000E, 10};

      // Reset state
      repeat (3) tick();
      rst = 1'b0;
      tick();
      check("reset/busy", 32'(busy), 32'd0);
      check("reset/hi", hi, 32'd0);
      check("reset/lo", lo, 32'd0);

      // Table-driven operations
      foreach (vecs[i]) begin
         preload(vecs[i].pre_hi, vecs[i].pre_lo);
         check($sformatf("vec%0d/pre_hi", i), hi, vecs[i].pre_hi);
         check($sformatf("vec%0d/pre_lo", i), lo, vecs[i].pre_lo);
         push_exp(vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].n);
         drive_start(vecs[i].md, vecs[i].a, vecs[i].b);
         wait_done($sformatf("vec%0d", i));
      end

      // mthi alone after the divide-by-zero pattern: lo keeps its value
      preload(32'h11111111, 32'h11111111);
      a_in = 32'h12345678; hiwrite = 1'b1;
      tick();
      hiwrite = 1'b0;
      check("mthi/hi", hi, 32'h12345678);
      check("mthi/lo", lo, 32'h11111111);

      // Back-to-back: div issued on the edge where multu commits
      drive_start(MD_MULTU, 32'hFFFFFFFE, 32'd3);
      repeat (4) tick();
      check("b2b/busy_last", 32'(busy), 32'd1);
      push_exp(32'hFFFFFFFF, 32'hFFFFFFFD, 10);
      drive_start(MD_DIV, 32'hFFFFFFF9, 32'd2);
      check("b2b/multu_hi", hi, 32'h00000002);
      check("b2b/multu_lo", lo, 32'hFFFFFFFA);
      wait_done("b2b_div");

      // start with writes in the same cycle: writes dropped
      preload(32'hCAFEF00D, 32'hDEADBEEF);
      hiwrite = 1'b1; lowrite = 1'b1;
      push_exp(32'd0, 32'd6, 5);
      drive_start(MD_MULT, 32'd2, 32'd3);
      hiwrite = 1'b0; lowrite = 1'b0;
      check("startwr/hi", hi, 32'hCAFEF00D);
      check("startwr/lo", lo, 32'hDEADBEEF);
      wait_done("startwr");

      // Reserved mdctr: no effect
      drive_start(3'd5, 32'd9, 32'd9);
      check("reserved/busy", 32'(busy), 32'd0);
      tick();
      check("reserved/busy2", 32'(busy), 32'd0);
      check("reserved/lo", lo, 32'd6);

      // Reset at cycle 3 of a mult: nothing commits afterwards
      preload(32'h5A5A5A5A, 32'h5A5A5A5A);
      drive_start(MD_MULT, 32'd7, 32'd9);
      repeat (2) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rstrun/busy", 32'(busy), 32'd0);
      check("rstrun/hi", hi, 32'd0);
      check("rstrun/lo", lo, 32'd0);
      repeat (8) tick();
      check("rstrun/late_busy", 32'(busy), 32'd0);
      check("rstrun/late_lo", lo, 32'd0);

      // start and lowrite pulsed mid-run are ignored
      push_exp(32'd0, 32'd42, 2);
      drive_start(MD_MULT, 32'd6, 32'd7);
      repeat (2) tick();
      start = 1'b1; mdctr = MD_DIVU; a_in = 32'hDEAD0000; b_in = 32'd3; lowrite = 1'b1;
      tick();
      start = 1'b0; lowrite = 1'b0;
      wait_done("midrun");
      tick();
      check("midrun/busy_after", 32'(busy), 32'd0);
      check("midrun/lo_after", lo, 32'd42);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
